skid_buffer: RTL

SKID_BUFFER -- requirements
Module: skid_buffer

---
 rtl/skid_buffer.sv | 108 ++++++++++
 1 files changed

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - two-entry registered skid buffer with fully registered handshake outputs
// Optional SKID_BUFFER_LEVEL_EN adds a registered 2-bit occupancy output `level`.
module skid_buffer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [N-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
`ifdef SKID_BUFFER_LEVEL_EN
  ,
  output logic [1:0]   level
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   main_q, main_d;
  logic [N-1:0]   skid_q, skid_d;
  logic           s_ready_q, s_ready_d;
  logic           m_valid_q, m_valid_d;
  logic [1:0]     level_q, level_d;
  logic           s_fire;
  logic           m_fire;

  assign s_fire = s_valid && s_ready_q;
  assign m_fire = m_valid_q && m_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (s_fire) begin
          main_d  = s_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (s_fire && m_fire) begin
          main_d = s_data;
        end else if (s_fire) begin
          skid_d  = s_data;
          state_d = TWO;
        end else if (m_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // s_ready is low in TWO, so only a downstream transfer can move us.
        if (m_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Handshake outputs are registered from the next state, so m_ready never reaches s_ready combinationally.
    s_ready_d = (state_d != TWO);
    m_valid_d = (state_d != EMPTY);
    case (state_d)
      ONE:     level_d = 2'd1;
      TWO:     level_d = 2'd2;
      default: level_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      level_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      level_q   <= level_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = main_q;

`ifdef SKID_BUFFER_LEVEL_EN
  assign level = level_q;
`else
  logic unused_level;
  assign unused_level = ^level_q;
`endif

endmodule
